// File: rtl/rs_drive_pkg.sv
// Shared types and default constants for the RS flip-flop drive controller.
package rs_drive_pkg;

    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_PULSE_W    = 1;
    localparam int DEF_GAP_W      = 2;
    localparam int DEF_CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } drive_state_t;

endpackage

// File: rtl/rs_debounce.sv
// Button conditioner: two-stage synchronizer, debounce counter and
// rising-edge detector producing a one-cycle request per accepted press.
module rs_debounce
    import rs_drive_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             levelDly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The debounced level only flips after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer, debounce state and the delayed level used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            levelDly_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            levelDly_q <= level_q;
            cnt_q      <= cnt_d;
        end
    end

    assign rise_o = level_q & ~levelDly_q;

endmodule

// File: rtl/rs_drive_ctrl.sv
// Drive controller for the clocked RS flip-flop: arbitrates debounced set and
// clear requests, issues width-controlled s/r pulses with guard gaps, tracks
// the expected flip-flop state and latches a sticky error on feedback mismatch.
module rs_drive_ctrl
    import rs_drive_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int PULSE_W    = DEF_PULSE_W,
    parameter int GAP_W      = DEF_GAP_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic q_exp,
    output logic conflict,
    output logic err
);

    logic             riseS;
    logic             riseR;
    drive_state_t     state_q;
    drive_state_t     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             qExp_q;
    logic             qExp_d;
    logic             pendS_q;
    logic             pendS_d;
    logic             pendR_q;
    logic             pendR_d;
    logic             sFirst_q;
    logic             sFirst_d;
    logic             conflict_q;
    logic             conflict_d;
    logic             err_q;
    logic             err_d;
    logic             oldS;
    logic             oldR;
    logic             headIsSet;

    rs_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) uSetDeb (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (set_btn),
        .rise_o (riseS)
    );

    rs_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) uClrDeb (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (clr_btn),
        .rise_o (riseR)
    );

    // Next-state logic: serve the oldest pending request, drop redundant ones,
    // time pulse and gap, then merge in newly arrived requests and their order.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        qExp_d     = qExp_q;
        err_d      = err_q;
        oldS       = pendS_q;
        oldR       = pendR_q;
        headIsSet  = pendS_q && (!pendR_q || sFirst_q);
        conflict_d = riseS && riseR;
        case (state_q)
            IDLE: begin
                if (pendS_q || pendR_q) begin
                    if (headIsSet) begin
                        oldS = 1'b0;
                        if (!qExp_q) begin
                            state_d = PULSE_S;
                            qExp_d  = 1'b1;
                            cnt_d   = '0;
                        end
                    end else begin
                        oldR = 1'b0;
                        if (qExp_q) begin
                            state_d = PULSE_R;
                            qExp_d  = 1'b0;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            PULSE_S, PULSE_R: begin
                if (cnt_q == CNT_W'(PULSE_W - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_W - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (q_fb != qExp_q) begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pendR_d = oldR || riseR;
        pendS_d = oldS || (riseS && !riseR);
        if (oldS && oldR) begin
            sFirst_d = sFirst_q;
        end else if (oldS) begin
            sFirst_d = 1'b1;
        end else if (oldR) begin
            sFirst_d = 1'b0;
        end else begin
            sFirst_d = pendS_d;
        end
    end

    // State, counter, expected-state, pending and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            qExp_q     <= 1'b0;
            pendS_q    <= 1'b0;
            pendR_q    <= 1'b0;
            sFirst_q   <= 1'b0;
            conflict_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qExp_q     <= qExp_d;
            pendS_q    <= pendS_d;
            pendR_q    <= pendR_d;
            sFirst_q   <= sFirst_d;
            conflict_q <= conflict_d;
            err_q      <= err_d;
        end
    end

    assign s        = (state_q == PULSE_S);
    assign r        = (state_q == PULSE_R);
    assign busy     = (state_q != IDLE);
    assign q_exp    = qExp_q;
    assign conflict = conflict_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rs_drive_ctrl.sv
// Self-checking bench for rs_drive_ctrl driving a behavioural RS flip-flop.
module tb_rs_drive_ctrl;

    localparam int DEB     = 4;
    localparam int PW      = 1;
    localparam int GW      = 2;
    localparam int LAT     = 3 + DEB;
    localparam int SPACING = PW + GW + 1;

    localparam int OP_SET        = 0;
    localparam int OP_CLR        = 1;
    localparam int OP_BOTH       = 2;
    localparam int OP_CLR_SET    = 3;
    localparam int OP_SET_CLR    = 4;
    localparam int OP_BOUNCE_SET = 5;
    localparam int OP_BOUNCE_CLR = 6;

    typedef struct {
        bit isSet;
        int edgeNo;
    } pulse_t;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    logic setBtn;
    logic clrBtn;
    logic qFb;
    logic s, r, busy, qExp, conflict, err;
    logic s4, r4, busy4, qExp4, conflict4, err4;
    logic ffQ;
    logic forceLow;

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    pulse_t expQ[$];
    bit     mQ;
    bit     mErr;
    int     nextFree;
    int     expConflicts = 0;
    int     seenConflicts = 0;

    bit     prevS, prevR, prevBusy;
    int     runLen, busyLen;
    pulse_t ev;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the clocked RS flip-flop.
    always @(posedge clk) begin
        if (rst) ffQ <= 1'b0;
        else if (s) ffQ <= 1'b1;
        else if (r) ffQ <= 1'b0;
    end

    assign qFb = forceLow ? 1'b0 : ffQ;

    rs_drive_ctrl dut (
        .clk(clk), .rst(rst), .set_btn(setBtn), .clr_btn(clrBtn), .q_fb(qFb),
        .s(s), .r(r), .busy(busy), .q_exp(qExp), .conflict(conflict), .err(err)
    );

    rs_drive_ctrl #(.PULSE_W(4)) dut4 (
        .clk(clk), .rst(rst4), .set_btn(setBtn), .clr_btn(clrBtn), .q_fb(qExp4),
        .s(s4), .r(r4), .busy(busy4), .q_exp(qExp4), .conflict(conflict4), .err(err4)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, required %0d (edge %0d)", name, actual, expected, cyc);
    endtask

    // Reference model: requests are served in arrival order, each no earlier
    // than its ready edge nor before the previous pulse has finished its gap.
    task automatic modelRequest(input bit isSet, input int ready);
        int start;
        pulse_t p;
        start = (ready > nextFree) ? ready : nextFree;
        if (isSet == mQ) begin
            nextFree = start + 1;
        end else begin
            p.isSet  = isSet;
            p.edgeNo = start;
            expQ.push_back(p);
            mQ = isSet;
            nextFree = start + SPACING;
            if (forceLow && isSet) mErr = 1'b1;
        end
    endtask

    task automatic driveBtn(input bit isSet, input bit lvl);
        if (isSet) setBtn = lvl;
        else clrBtn = lvl;
    endtask

    task automatic bounceButton(input bit isSet, output int kEdge);
        int elapsed;
        int h;
        bit lvl;
        elapsed = 0;
        lvl = 1'b0;
        kEdge = cyc + 1;
        while (elapsed < 20) begin
            h = $urandom_range(1, DEB - 1);
            lvl = ~lvl;
            driveBtn(isSet, lvl);
            if (lvl) kEdge = cyc + 1;
            repeat (h) @(posedge clk);
            #1;
            elapsed += h;
        end
        if (!lvl) begin
            driveBtn(isSet, 1'b1);
            kEdge = cyc + 1;
        end
    endtask

    task automatic endChecks();
        @(negedge clk);
        checkOutput("q_exp", int'(qExp), int'(mQ));
        checkOutput("err", int'(err), int'(mErr));
        checkOutput("conflict_count", seenConflicts, expConflicts);
        checkOutput("outstanding_pulses", expQ.size(), 0);
    endtask

    task automatic applyStimulus(input int op);
        int k;
        @(posedge clk);
        #1;
        k = cyc + 1;
        case (op)
            OP_SET: begin setBtn = 1'b1; modelRequest(1'b1, k + LAT); end
            OP_CLR: begin clrBtn = 1'b1; modelRequest(1'b0, k + LAT); end
            OP_BOTH: begin
                setBtn = 1'b1;
                clrBtn = 1'b1;
                modelRequest(1'b0, k + LAT);
                expConflicts++;
            end
            OP_CLR_SET: begin
                clrBtn = 1'b1;
                modelRequest(1'b0, k + LAT);
                @(posedge clk);
                #1;
                setBtn = 1'b1;
                modelRequest(1'b1, k + 1 + LAT);
            end
            OP_SET_CLR: begin
                setBtn = 1'b1;
                modelRequest(1'b1, k + LAT);
                @(posedge clk);
                #1;
                clrBtn = 1'b1;
                modelRequest(1'b0, k + 1 + LAT);
            end
            OP_BOUNCE_SET: begin bounceButton(1'b1, k); modelRequest(1'b1, k + LAT); end
            default: begin bounceButton(1'b0, k); modelRequest(1'b0, k + LAT); end
        endcase
        repeat (12) @(posedge clk);
        #1;
        setBtn = 1'b0;
        clrBtn = 1'b0;
        repeat (25) @(posedge clk);
        endChecks();
    endtask

    // Monitor: pops the scoreboard on every pulse start and checks shape.
    always @(negedge clk) begin
        if (rst) begin
            prevS = 1'b0; prevR = 1'b0; prevBusy = 1'b0; runLen = 0; busyLen = 0;
        end else begin
            if (s && r) begin
                checks++;
                $display("[TB] FAIL sr_overlap: s=%0b r=%0b at edge %0d, required never both", s, r, cyc);
            end
            if ((s && !prevS) || (r && !prevR)) begin
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_pulse: s=%0b r=%0b at edge %0d, required none", s, r, cyc);
                end else begin
                    ev = expQ.pop_front();
                    checkOutput("pulse_kind_s", int'(s), int'(ev.isSet));
                    checkOutput("pulse_edge", cyc, ev.edgeNo);
                    checkOutput("q_exp_at_pulse", int'(qExp), int'(ev.isSet));
                end
            end
            if (s || r) runLen++;
            else if (prevS || prevR) begin
                checkOutput("pulse_width", runLen, PW);
                runLen = 0;
            end
            if (busy) busyLen++;
            else if (prevBusy) begin
                checkOutput("busy_length", busyLen, PW + GW);
                busyLen = 0;
            end
            if (conflict) seenConflicts++;
            prevS = s;
            prevR = r;
            prevBusy = busy;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idleHits;
        int k;
        bit found;
        setBtn = 1'b0; clrBtn = 1'b0; forceLow = 1'b0;
        rst = 1'b1; rst4 = 1'b1;
        mQ = 1'b0; mErr = 1'b0; nextFree = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        checkOutput("reset_s", int'(s), 0);
        checkOutput("reset_r", int'(r), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_q_exp", int'(qExp), 0);
        checkOutput("reset_conflict", int'(conflict), 0);
        checkOutput("reset_err", int'(err), 0);

        idleHits = 0;
        repeat (50) begin
            @(negedge clk);
            if (s || r) idleHits++;
        end
        checkOutput("idle_no_pulses", idleHits, 0);

        applyStimulus(OP_SET);
        applyStimulus(OP_BOUNCE_CLR);
        applyStimulus(OP_SET);
        applyStimulus(OP_BOTH);
        applyStimulus(OP_BOTH);
        applyStimulus(OP_SET);
        applyStimulus(OP_SET);
        applyStimulus(OP_CLR_SET);
        applyStimulus(OP_SET_CLR);
        applyStimulus(OP_CLR_SET);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(int'($urandom_range(0, 6)));
        end

        applyStimulus(OP_CLR);
        forceLow = 1'b1;
        applyStimulus(OP_SET);
        repeat (10) @(negedge clk);
        checkOutput("err_sticky", int'(err), 1);
        forceLow = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1; rst4 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; rst4 = 1'b0;
        mQ = 1'b0; mErr = 1'b0; nextFree = 0;
        @(negedge clk);
        checkOutput("err_after_reset", int'(err), 0);
        checkOutput("q_exp_after_reset", int'(qExp), 0);
        checkOutput("busy_after_reset", int'(busy), 0);

        @(posedge clk);
        #1;
        k = cyc + 1;
        setBtn = 1'b1;
        modelRequest(1'b1, k + LAT);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s4) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("wide_pulse_seen", int'(found), 1);
        if (found) begin
            @(posedge clk);
            #1;
            rst4 = 1'b1;
            @(negedge clk);
            checkOutput("wide_s_before_reset", int'(s4), 1);
            @(posedge clk);
            @(negedge clk);
            checkOutput("wide_s_after_reset", int'(s4), 0);
            checkOutput("wide_busy_after_reset", int'(busy4), 0);
            checkOutput("wide_q_exp_after_reset", int'(qExp4), 0);
            checkOutput("wide_err_after_reset", int'(err4), 0);
            rst4 = 1'b0;
        end
        repeat (12) @(posedge clk);
        #1;
        setBtn = 1'b0;
        repeat (25) @(posedge clk);
        endChecks();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
